writeback_pipe: RTL and testbench

WRITEBACK_PIPE -- requirements
Module: writeback_pipe

---
 rtl/writeback_pipe_pkg.sv | 28 ++
 rtl/forward_select.sv | 41 ++++
 rtl/writeback_pipe.sv | 84 ++++++++
 tb/tb_writeback_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_pipe_pkg.sv
// Shared SPU writeback types: pipe entry layout, depth and operand slots.
// Imported by the writeback pipe and its forwarding selector.
package writeback_pipe_pkg;

    localparam int PIPE_DEPTH  = 7;
    localparam int FLUSH_DEPTH = 3;
    localparam int NUM_OPS     = 6;

    localparam int OP_RA_EVEN   = 0;
    localparam int OP_RB_EVEN   = 1;
    localparam int OP_RC_EVEN   = 2;
    localparam int OP_RA_ODD    = 3;
    localparam int OP_RB_ODD    = 4;
    localparam int OP_RT_ST_ODD = 5;

    typedef struct packed {
        logic [6:0]   addr;
        logic [127:0] value;
        logic         write;
        logic [2:0]   latency;
    } wb_entry_t;

    // Latencies below 2 are treated as 2: nothing is ready at stage 1.
    function automatic logic [2:0] eff_latency(input logic [2:0] lat);
        return (lat < 3'd2) ? 3'd2 : lat;
    endfunction

endpackage

// File: rtl/forward_select.sv
// Per-operand forwarding search over both pipes.
// Youngest match wins; at equal stage the odd pipe wins.
module forward_select
    import writeback_pipe_pkg::*;
(
    input  logic [6:0]                  src,
    input  wb_entry_t [PIPE_DEPTH-1:0]  even_st,
    input  wb_entry_t [PIPE_DEPTH-1:0]  odd_st,
    output logic                        hit,
    output logic [127:0]                value,
    output logic                        pending
);

    logic         found;
    logic         sel_valid;
    logic [127:0] sel_value;

    // Walk stage 1 -> 7 and latch the first matching entry.
    always_comb begin
        found     = 1'b0;
        sel_valid = 1'b0;
        sel_value = '0;
        for (int s = 0; s < PIPE_DEPTH; s++) begin
            if (!found && odd_st[s].write && odd_st[s].addr == src) begin
                found     = 1'b1;
                sel_valid = 3'(s + 1) >= eff_latency(odd_st[s].latency);
                sel_value = odd_st[s].value;
            end else if (!found && even_st[s].write &&
                         even_st[s].addr == src) begin
                found     = 1'b1;
                sel_valid = 3'(s + 1) >= eff_latency(even_st[s].latency);
                sel_value = even_st[s].value;
            end
        end
    end

    assign hit     = found && sel_valid;
    assign value   = hit ? sel_value : '0;
    assign pending = found && !sel_valid;

endmodule

// File: rtl/writeback_pipe.sv
// SPU even/odd writeback pipes with result forwarding and stall detect.
// Stage 7 of each pipe drives the register file write port.
module writeback_pipe
    import writeback_pipe_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic [6:0]   rt_addr_even_in,
    input  logic [6:0]   rt_addr_odd_in,
    input  logic [127:0] rt_even_in,
    input  logic [127:0] rt_odd_in,
    input  logic         reg_write_even_in,
    input  logic         reg_write_odd_in,
    input  logic [2:0]   latency_even_in,
    input  logic [2:0]   latency_odd_in,
    input  logic         flush,
    input  logic [41:0]  src_addr,
    output logic [5:0]   fwd_hit,
    output logic [767:0] fwd_value,
    output logic         stall,
    output logic [6:0]   rt_addr_even_wb,
    output logic [6:0]   rt_addr_odd_wb,
    output logic [127:0] rt_even_wb,
    output logic [127:0] rt_odd_wb,
    output logic         reg_write_even_wb,
    output logic         reg_write_odd_wb
);

    wb_entry_t [PIPE_DEPTH-1:0] even_q, even_nx;
    wb_entry_t [PIPE_DEPTH-1:0] odd_q, odd_nx;
    wb_entry_t                  even_new, odd_new;
    logic      [NUM_OPS-1:0]    pend;

    assign even_new = '{addr: rt_addr_even_in, value: rt_even_in,
                        write: reg_write_even_in, latency: latency_even_in};
    assign odd_new  = '{addr: rt_addr_odd_in, value: rt_odd_in,
                        write: reg_write_odd_in, latency: latency_odd_in};

    // Shift both pipes by one; a flush kills what lands in stages 1-3.
    always_comb begin
        even_nx = {even_q[PIPE_DEPTH-2:0], even_new};
        odd_nx  = {odd_q[PIPE_DEPTH-2:0], odd_new};
        if (flush) begin
            for (int s = 0; s < FLUSH_DEPTH; s++) begin
                even_nx[s].write = 1'b0;
                odd_nx[s].write  = 1'b0;
            end
        end
    end

    // Pipe registers; reset wipes every in-flight entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            even_q <= '0;
            odd_q  <= '0;
        end else begin
            even_q <= even_nx;
            odd_q  <= odd_nx;
        end
    end

    assign rt_addr_even_wb = even_q[PIPE_DEPTH-1].addr;
    assign rt_even_wb      = even_q[PIPE_DEPTH-1].value;
    assign rt_addr_odd_wb  = odd_q[PIPE_DEPTH-1].addr;
    assign rt_odd_wb       = odd_q[PIPE_DEPTH-1].value;
    assign reg_write_odd_wb = odd_q[PIPE_DEPTH-1].write;
    assign reg_write_even_wb = even_q[PIPE_DEPTH-1].write &&
        !(odd_q[PIPE_DEPTH-1].write &&
          odd_q[PIPE_DEPTH-1].addr == even_q[PIPE_DEPTH-1].addr);

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
        forward_select u_sel (
            .src     (src_addr[i*7 +: 7]),
            .even_st (even_q),
            .odd_st  (odd_q),
            .hit     (fwd_hit[i]),
            .value   (fwd_value[i*128 +: 128]),
            .pending (pend[i])
        );
    end

    assign stall = |pend;

endmodule

// File: tb/tb_writeback_pipe.sv
// Bench for writeback_pipe: issue-log model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_writeback_pipe;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [6:0]   ae, ao;
    logic [127:0] ve, vo;
    logic         we, wo;
    logic [2:0]   le, lo;
    logic         flush;
    logic [41:0]  src_addr;
    logic [5:0]   fwd_hit;
    logic [767:0] fwd_value;
    logic         stall;
    logic [6:0]   rt_addr_even_wb, rt_addr_odd_wb;
    logic [127:0] rt_even_wb, rt_odd_wb;
    logic         reg_write_even_wb, reg_write_odd_wb;

    writeback_pipe dut (
        .clock             (clock),
        .reset             (reset),
        .rt_addr_even_in   (ae),
        .rt_addr_odd_in    (ao),
        .rt_even_in        (ve),
        .rt_odd_in         (vo),
        .reg_write_even_in (we),
        .reg_write_odd_in  (wo),
        .latency_even_in   (le),
        .latency_odd_in    (lo),
        .flush             (flush),
        .src_addr          (src_addr),
        .fwd_hit           (fwd_hit),
        .fwd_value         (fwd_value),
        .stall             (stall),
        .rt_addr_even_wb   (rt_addr_even_wb),
        .rt_addr_odd_wb    (rt_addr_odd_wb),
        .rt_even_wb        (rt_even_wb),
        .rt_odd_wb         (rt_odd_wb),
        .reg_write_even_wb (reg_write_even_wb),
        .reg_write_odd_wb  (reg_write_odd_wb)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // issue log: index k = k-th clock edge since start of logging
    int           ecount = 0;
    logic [6:0]   le_addr[0:511], lo_addr[0:511];
    logic [127:0] le_val[0:511], lo_val[0:511];
    logic         le_wr[0:511], lo_wr[0:511];
    logic [2:0]   le_lat[0:511], lo_lat[0:511];

    logic [6:0]   m_ae, m_ao;
    logic [127:0] m_ve, m_vo;
    logic         m_rwe, m_rwo;
    logic [5:0]   m_hit;
    logic [767:0] m_val;
    logic         m_stall;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int eff(input logic [2:0] l);
        return (l < 2) ? 2 : int'(l);
    endfunction

    // An instruction logged at edge k sits at stage ecount-k+1.
    task automatic model_eval();
        int k;
        logic [6:0] a;
        bit found, ok;
        logic [127:0] v;
        k = ecount - 6;
        if (k >= 1) begin
            m_ae = le_addr[k]; m_ve = le_val[k]; m_rwe = le_wr[k];
            m_ao = lo_addr[k]; m_vo = lo_val[k]; m_rwo = lo_wr[k];
        end else begin
            m_ae = '0; m_ve = '0; m_rwe = 1'b0;
            m_ao = '0; m_vo = '0; m_rwo = 1'b0;
        end
        if (m_rwo && m_ao == m_ae) m_rwe = 1'b0;
        m_stall = 1'b0;
        m_hit = '0;
        m_val = '0;
        for (int i = 0; i < 6; i++) begin
            a = src_addr[i*7 +: 7];
            found = 0; ok = 0; v = '0;
            for (int s = 1; s <= 7; s++) begin
                k = ecount - s + 1;
                if (!found && k >= 1) begin
                    if (lo_wr[k] && lo_addr[k] == a) begin
                        found = 1; ok = (s >= eff(lo_lat[k])); v = lo_val[k];
                    end else if (le_wr[k] && le_addr[k] == a) begin
                        found = 1; ok = (s >= eff(le_lat[k])); v = le_val[k];
                    end
                end
            end
            if (found && ok) begin
                m_hit[i] = 1'b1;
                m_val[i*128 +: 128] = v;
            end else if (found) begin
                m_stall = 1'b1;
            end
        end
    endtask

    task automatic model_clear();
        for (int k = 1; k <= ecount; k++) begin
            le_addr[k] = '0; le_val[k] = '0; le_wr[k] = 0; le_lat[k] = '0;
            lo_addr[k] = '0; lo_val[k] = '0; lo_wr[k] = 0; lo_lat[k] = '0;
        end
    endtask

    // compare everything against the model on every falling edge
    always @(negedge clock) begin
        if (chk_en) begin
            model_eval();
            chk("wb_addr_even", 128'(rt_addr_even_wb), 128'(m_ae));
            chk("wb_addr_odd", 128'(rt_addr_odd_wb), 128'(m_ao));
            chk("wb_val_even", rt_even_wb, m_ve);
            chk("wb_val_odd", rt_odd_wb, m_vo);
            chk("wb_we_even", 128'(reg_write_even_wb), 128'(m_rwe));
            chk("wb_we_odd", 128'(reg_write_odd_wb), 128'(m_rwo));
            chk("stall", 128'(stall), 128'(m_stall));
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("fwd_hit%0d", i), 128'(fwd_hit[i]),
                    128'(m_hit[i]));
                chk($sformatf("fwd_val%0d", i), fwd_value[i*128 +: 128],
                    m_val[i*128 +: 128]);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        if (reset) begin
            ecount++;
            le_addr[ecount] = ae; le_val[ecount] = ve;
            le_wr[ecount] = we; le_lat[ecount] = le;
            lo_addr[ecount] = ao; lo_val[ecount] = vo;
            lo_wr[ecount] = wo; lo_lat[ecount] = lo;
            if (flush) begin
                for (int j = 0; j < 3; j++) begin
                    if (ecount - j >= 1) begin
                        le_wr[ecount-j] = 0;
                        lo_wr[ecount-j] = 0;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        we = 0; wo = 0; ae = '0; ao = '0; ve = '0; vo = '0;
        le = '0; lo = '0;
    endtask

    task automatic iss_e(input logic [6:0] a, input logic [127:0] v,
                         input logic [2:0] l);
        we = 1; ae = a; ve = v; le = l;
    endtask

    task automatic iss_o(input logic [6:0] a, input logic [127:0] v,
                         input logic [2:0] l);
        wo = 1; ao = a; vo = v; lo = l;
    endtask

    task automatic set_src(input logic [6:0] a0, a1, a2, a3, a4, a5);
        src_addr = {a5, a4, a3, a2, a1, a0};
    endtask

    localparam logic [127:0] V1 = 128'hA7E5_0000_1111_2222_3333_4444_5555_66E9;
    localparam logic [127:0] V2 = 128'h0707_0707_0000_0000_DEAD_BEEF_0000_0007;
    localparam logic [127:0] VE3 = 128'hEEEE_0000_0000_0000_0000_0000_0000_0005;
    localparam logic [127:0] VO3 = 128'h0DD0_0000_0000_0000_0000_0000_0000_0005;
    localparam logic [127:0] VA = 128'h9999_AAAA_0000_0000_0000_0000_0000_0009;
    localparam logic [127:0] VB = 128'h9999_BBBB_0000_0000_0000_0000_0000_0009;
    localparam logic [127:0] VC = 128'h4040_CCCC_0000_0000_0000_0000_0000_0040;

    initial begin
        idle();
        flush = 0;
        set_src(7'd5, 7'd100, 7'd101, 7'd102, 7'd103, 7'd104);
        #3;
        chk("rst_we_even", 128'(reg_write_even_wb), 128'd0);
        chk("rst_stall", 128'(stall), 128'd0);
        chk("rst_hit", 128'(fwd_hit), 128'd0);
        #9 reset = 1;
        chk_en = 1;

        // even result, latency 2, reaches stage 7 after seven edges
        iss_e(7'd5, V1, 3'd2);
        tick();
        idle();
        repeat (6) tick();
        chk("t1_we", 128'(reg_write_even_wb), 128'd1);
        chk("t1_addr", 128'(rt_addr_even_wb), 128'd5);
        chk("t1_val", rt_even_wb, V1);

        // odd latency 4 probed by ra_odd through every stage
        set_src(7'd100, 7'd101, 7'd102, 7'd7, 7'd103, 7'd104);
        iss_o(7'd7, V2, 3'd4);
        tick();
        idle();
        for (int s = 1; s <= 7; s++) begin
            chk($sformatf("t2_stall_s%0d", s), 128'(stall),
                (s <= 3) ? 128'd1 : 128'd0);
            chk($sformatf("t2_hit_s%0d", s), 128'(fwd_hit[3]),
                (s <= 3) ? 128'd0 : 128'd1);
            if (s >= 4)
                chk($sformatf("t2_val_s%0d", s), fwd_value[3*128 +: 128], V2);
            tick();
        end

        // both pipes write r5 in the same cycle: odd wins
        set_src(7'd5, 7'd100, 7'd101, 7'd102, 7'd103, 7'd104);
        iss_e(7'd5, VE3, 3'd2);
        iss_o(7'd5, VO3, 3'd2);
        tick();
        idle();
        repeat (6) tick();
        chk("t3_we_odd", 128'(reg_write_odd_wb), 128'd1);
        chk("t3_we_even", 128'(reg_write_even_wb), 128'd0);
        chk("t3_fwd_hit", 128'(fwd_hit[0]), 128'd1);
        chk("t3_fwd_val", fwd_value[127:0], VO3);

        // r9 old at stage 6, young at stage 2: young wins
        set_src(7'd100, 7'd9, 7'd101, 7'd102, 7'd103, 7'd104);
        tick();
        iss_e(7'd9, VA, 3'd3);
        tick();
        idle();
        repeat (3) tick();
        iss_o(7'd9, VB, 3'd2);
        tick();
        idle();
        chk("t4_stall_young", 128'(stall), 128'd1);
        chk("t4_hit_young", 128'(fwd_hit[1]), 128'd0);
        tick();
        chk("t4_hit", 128'(fwd_hit[1]), 128'd1);
        chk("t4_val", fwd_value[1*128 +: 128], VB);
        chk("t4_stall", 128'(stall), 128'd0);
        repeat (6) tick();

        // latency 0 is treated as 2
        set_src(7'd100, 7'd101, 7'd102, 7'd103, 7'd104, 7'd40);
        iss_o(7'd40, VC, 3'd0);
        tick();
        idle();
        chk("t5_stall", 128'(stall), 128'd1);
        chk("t5_hit_s1", 128'(fwd_hit[5]), 128'd0);
        tick();
        chk("t5_hit_s2", 128'(fwd_hit[5]), 128'd1);
        chk("t5_val", fwd_value[5*128 +: 128], VC);
        repeat (6) tick();

        // flush lands five entries in stages 1-5; stages 1-3 die
        set_src(7'd100, 7'd101, 7'd22, 7'd103, 7'd104, 7'd105);
        for (int j = 0; j < 4; j++) begin
            iss_e(7'(20 + j), 128'(32'hF000_0020 + j), 3'd2);
            iss_o(7'(60 + j), 128'(32'h0D00_0060 + j), 3'd2);
            tick();
        end
        iss_e(7'd24, 128'h24, 3'd2);
        iss_o(7'd64, 128'h64, 3'd2);
        flush = 1;
        tick();
        flush = 0;
        idle();
        chk("t6_hit_killed", 128'(fwd_hit[2]), 128'd0);
        tick();
        tick();
        chk("t6_we20", 128'(reg_write_even_wb), 128'd1);
        chk("t6_addr20", 128'(rt_addr_even_wb), 128'd20);
        chk("t6_wo60", 128'(reg_write_odd_wb), 128'd1);
        tick();
        chk("t6_we21", 128'(reg_write_even_wb), 128'd1);
        tick();
        chk("t6_addr22", 128'(rt_addr_even_wb), 128'd22);
        chk("t6_we22", 128'(reg_write_even_wb), 128'd0);
        chk("t6_wo62", 128'(reg_write_odd_wb), 128'd0);
        tick();
        chk("t6_we23", 128'(reg_write_even_wb), 128'd0);
        tick();
        chk("t6_we24", 128'(reg_write_even_wb), 128'd0);
        tick();

        // asynchronous reset mid-cycle with four entries in flight
        set_src(7'd30, 7'd31, 7'd32, 7'd33, 7'd100, 7'd101);
        iss_e(7'd30, 128'h30, 3'd2);
        iss_o(7'd31, 128'h31, 3'd2);
        tick();
        iss_e(7'd32, 128'h32, 3'd2);
        iss_o(7'd33, 128'h33, 3'd2);
        tick();
        idle();
        tick();
        tick();
        chk("t7_pre_hit", 128'(fwd_hit[0]), 128'd1);
        #1 reset = 0;
        #1;
        chk("t7_hit", 128'(fwd_hit), 128'd0);
        chk("t7_val", 128'(|fwd_value), 128'd0);
        chk("t7_stall", 128'(stall), 128'd0);
        chk("t7_we_e", 128'(reg_write_even_wb), 128'd0);
        chk("t7_we_o", 128'(reg_write_odd_wb), 128'd0);
        chk("t7_addr_e", 128'(rt_addr_even_wb), 128'd0);
        chk("t7_addr_o", 128'(rt_addr_odd_wb), 128'd0);
        chk("t7_val_e", rt_even_wb, 128'd0);
        chk("t7_val_o", rt_odd_wb, 128'd0);
        model_clear();
        reset = 1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("t7_post_we_e%0d", c), 128'(reg_write_even_wb),
                128'd0);
            chk($sformatf("t7_post_we_o%0d", c), 128'(reg_write_odd_wb),
                128'd0);
        end

        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
